// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with majority-vote sampling and FWFT byte FIFO
module uart_rx_fifo #(
    parameter int CLOCK_SPEED = 50000000,
    parameter int BAUD_RATE   = 460800,
    parameter int DATA_LENGTH = 8,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_pin,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int BIT_PERIOD  = CLOCK_SPEED / BAUD_RATE;
    localparam int HALF_PERIOD = BIT_PERIOD / 2;
    localparam int CNT_W       = $clog2(BIT_PERIOD);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CW          = PTR_W + 1;

    typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q;
    logic [2:0]         hist_q;
    logic [1:0]         prime_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic               stop_idx_q, stop_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               push_q, push_d;
    logic               frame_err_q, frame_err_d;
    logic               overflow_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic line_s, maj, primed, pop, full, wr_en;

    assign line_s = sync_q[1];
    assign maj    = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    // Reset values of the synchroniser say nothing about the real line; wait until
    // it has been refilled from the pin before trusting an idle-high level.
    assign primed = prime_q[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            WAIT_HIGH: if (primed && line_s) state_d = IDLE;
            IDLE: begin
                if (!line_s) begin
                    state_d   = START;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    shift_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_W'(HALF_PERIOD - 1)) begin
                    cnt_d   = '0;
                    state_d = maj ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(BIT_PERIOD - 1)) begin
                    cnt_d                  = '0;
                    shift_d                = {1'b0, shift_q[7:1]};
                    shift_d[DATA_LENGTH-1] = maj;
                    bit_idx_d              = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DATA_LENGTH - 1)) begin
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_W'(BIT_PERIOD - 1)) begin
                    cnt_d = '0;
                    if (!maj) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        push_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_HIGH;
            sync_q      <= 2'b11;
            hist_q      <= 3'b111;
            prime_q     <= 2'b00;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], rx_pin};
            hist_q      <= {hist_q[1:0], line_s};
            prime_q     <= primed ? prime_q : prime_q + 2'd1;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
        end
    end

    // A pop frees the head slot in the same edge, so a full FIFO still accepts a push.
    assign pop   = rd_en && (count_q != '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign wr_en = push_q && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_q && full && !pop;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign rx_busy    = (state_q != IDLE);
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int BIT  = 108;
    localparam int HALF = 54;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx0, rx1, rd_en0, rd_en1;
    logic [7:0] rd_data0, rd_data1;
    logic       rd_valid0, rd_valid1, rx_busy0, rx_busy1;
    logic       frame_err0, frame_err1, overflow0, overflow1;
    logic [4:0] fifo_count0, fifo_count1;

    int n_checks = 0;
    int n_fail   = 0;
    int fe0 = 0, ov0 = 0, fe1 = 0, ov1 = 0, both0 = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut0 (
        .clk(clk), .reset(reset), .rx_pin(rx0), .rd_en(rd_en0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .fifo_count(fifo_count0),
        .rx_busy(rx_busy0), .frame_err(frame_err0), .overflow(overflow0)
    );

    uart_rx_fifo #(.DATA_LENGTH(7), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .rx_pin(rx1), .rd_en(rd_en1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .fifo_count(fifo_count1),
        .rx_busy(rx_busy1), .frame_err(frame_err1), .overflow(overflow1)
    );

    always @(negedge clk) begin
        if (frame_err0) fe0++;
        if (overflow0)  ov0++;
        if (frame_err1) fe1++;
        if (overflow1)  ov1++;
        if (frame_err0 && overflow0) both0++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rx(input bit which, input logic v);
        if (which) rx1 = v;
        else       rx0 = v;
    endtask

    task automatic drive_bit(input bit which, input logic v, input bit glitch);
        for (int i = 0; i < BIT; i++) begin
            @(negedge clk);
            set_rx(which, (glitch && i == HALF) ? ~v : v);
        end
    endtask

    task automatic send_body(input bit which, input logic [7:0] b, input int dl);
        drive_bit(which, 1'b0, 1'b0);
        for (int i = 0; i < dl; i++) drive_bit(which, b[i], 1'b0);
    endtask

    task automatic send_byte(input bit which, input logic [7:0] b, input int dl, input int sb);
        send_body(which, b, dl);
        for (int i = 0; i < sb; i++) drive_bit(which, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, rd_valid0, 1'b1);
        check(tag, rd_data0, exp);
        rd_en0 = 1'b1;
        @(negedge clk);
        rd_en0 = 1'b0;
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_fe, base_ov;
        bit found;

        reset = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rd_en0 = 1'b0; rd_en1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", rx_busy0, 1'b1);
        check("rst_count", fifo_count0, 0);
        check("rst_valid", rd_valid0, 1'b0);
        check("rst_data", rd_data0, 8'h00);
        check("rst_errs", {frame_err0, overflow0}, 2'b00);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_busy", rx_busy0, 1'b0);

        // 1: single 8N1 byte, rd_valid timing relative to stop-bit mid-point
        send_body(1'b0, 8'hA5, 8);
        found = 1'b0;
        for (int i = 0; i < HALF + BIT + 3; i++) begin
            @(negedge clk);
            rx0 = 1'b1;
            if (rd_valid0) begin
                found = 1'b1;
                break;
            end
        end
        check("t1_valid_in_time", found, 1'b1);
        repeat (BIT) @(negedge clk);
        check("t1_count", fifo_count0, 1);
        check("t1_errs", fe0 + ov0, 0);
        pop_expect("t1_data", 8'hA5);
        check("t1_empty", rd_valid0, 1'b0);

        // 2: short low pulse is rejected as a glitch start
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rx0 = (i < 20) ? 1'b0 : 1'b1;
            if (i == 30) check("t2_busy_start", rx_busy0, 1'b1);
            if (i == 80) check("t2_back_idle", rx_busy0, 1'b0);
        end
        check("t2_no_push", fifo_count0, 0);
        drive_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(1'b0, 1'b1, i == 3);
        drive_bit(1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        pop_expect("t2_glitch_ff", 8'hFF);

        // 3: framing error on 0x3C, then a good 0x55
        send_body(1'b0, 8'h3C, 8);
        drive_bit(1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b0);
        check("t3_fe_pulses", fe0, 1);
        check("t3_not_stored", fifo_count0, 0);
        send_byte(1'b0, 8'h55, 8, 1);
        check("t3_fe_total", fe0, 1);
        check("t3_count", fifo_count0, 1);
        pop_expect("t3_data", 8'h55);

        // 4: overflow on the 17th byte
        for (int i = 0; i < 16; i++) send_byte(1'b0, 8'(i), 8, 1);
        check("t4_count_full", fifo_count0, 16);
        check("t4_no_ov_yet", ov0, 0);
        send_byte(1'b0, 8'h10, 8, 1);
        check("t4_ov_pulse", ov0, 1);
        check("t4_count_held", fifo_count0, 16);
        for (int i = 0; i < 16; i++) pop_expect("t4_pop", 8'(i));
        check("t4_drained", rd_valid0, 1'b0);

        // 5: pop in the exact push cycle while full
        for (int i = 0; i < 16; i++) send_byte(1'b0, 8'(8'h20 + i), 8, 1);
        base_ov = ov0;
        send_body(1'b0, 8'h77, 8);
        found = 1'b0;
        for (int i = 0; i < BIT; i++) begin
            @(negedge clk);
            rx0 = 1'b1;
            if (dut0.push_q) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_push_seen", found, 1'b1);
        pop_expect("t5_head", 8'h20);
        repeat (BIT) @(negedge clk);
        check("t5_no_ov", ov0 - base_ov, 0);
        check("t5_count", fifo_count0, 16);
        for (int i = 1; i < 16; i++) pop_expect("t5_pop", 8'(8'h20 + i));
        pop_expect("t5_last", 8'h77);
        check("t5_drained", rd_valid0, 1'b0);

        // 6: reset mid-DATA with the line low, then a long low period
        send_byte(1'b0, 8'h42, 8, 1);
        base_fe = fe0;
        base_ov = ov0;
        drive_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_count", fifo_count0, 0);
        check("t6_rst_busy", rx_busy0, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0, 1'b0);
        check("t6_wait_high", rx_busy0, 1'b1);
        drive_bit(1'b0, 1'b1, 1'b0);
        check("t6_idle", rx_busy0, 1'b0);
        check("t6_nothing", fifo_count0, 0);
        send_byte(1'b0, 8'h81, 8, 1);
        check("t6_count", fifo_count0, 1);
        check("t6_errs", (fe0 - base_fe) + (ov0 - base_ov), 0);
        pop_expect("t6_data", 8'h81);

        // 7-bit data, two stop bits; second stop bit low must be a framing error
        send_byte(1'b1, 8'h5A, 7, 2);
        check("d7_count", fifo_count1, 1);
        check("d7_data", rd_data1, 8'h5A);
        check("d7_no_fe", fe1, 0);
        send_body(1'b1, 8'h12, 7);
        drive_bit(1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0);
        check("d7_fe_stop2", fe1, 1);
        check("d7_not_stored", fifo_count1, 1);
        check("no_fe_ov_overlap", both0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Standalone UART receiver that decodes the serial stream produced by the team's UART transmitters (LSB first, start bit 0, stop bit(s) 1, no parity). It synchronises rx_pin, majority-votes each bit at mid-period, checks the stop bit(s) for framing, and buffers good bytes in a first-word-fall-through FIFO. Consumers drain the FIFO with a valid/pop handshake, so byte-to-byte timing is decoupled from the line rate.

Parameters:
CLOCK_SPEED, 50000000, system clock frequency in Hz.
BAUD_RATE, 460800, line rate in bits per second. BIT_PERIOD = CLOCK_SPEED/BAUD_RATE (integer division; 108 at defaults). HALF_PERIOD = BIT_PERIOD/2 (54).
DATA_LENGTH, 8, data bits per frame; legal range 5..8.
STOP_BITS, 1, number of stop bits checked; legal values 1 or 2.
FIFO_DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
rx_pin  in  1  asynchronous serial input; idles high.
rd_en  in  1  pop request; honoured only when rd_valid=1.
rd_data  out  8  FIFO head byte; bits [7:DATA_LENGTH] are 0.
rd_valid  out  1  FIFO not empty.
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
rx_busy  out  1  high while the state machine is in any state other than IDLE.
frame_err  out  1  one-cycle pulse when a stop bit is sampled as 0.
overflow  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset is synchronous and active-high. On reset: 2-FF synchroniser and 3-sample history = all 1s; FIFO emptied (pointers 0, fifo_count=0, rd_valid=0); rd_data=0; frame_err=0; overflow=0; counters=0. The state after reset is WAIT_HIGH, so rx_busy=1.
- Synchroniser: rx_pin passes through 2 FFs (line_s). A 3-bit history shifts line_s every cycle. maj = majority of the 3 history bits.
- State WAIT_HIGH: go to IDLE when line_s=1. This prevents a false start after reset or a break condition.
- State IDLE: when line_s=0, go to START and clear the bit counter.
- State START: count clk cycles. When the count reaches HALF_PERIOD-1, evaluate maj.
  - maj=1: glitch; return to IDLE.
  - maj=0: clear the counter and go to DATA.
- State DATA: each time the counter reaches BIT_PERIOD-1, shift maj into the shift register LSB first, increment the bit index, and clear the counter. After DATA_LENGTH bits, go to STOP.
- State STOP: sample maj every BIT_PERIOD cycles for STOP_BITS samples.
  - All samples 1: push the byte, then go to IDLE.
  - Any sample 0: pulse frame_err for 1 cycle, discard the byte, and go to WAIT_HIGH. No further stop samples are taken.
- Push happens in the cycle after the last stop sample. rd_valid rises the cycle after the push if the FIFO was empty.
- FIFO is first-word-fall-through: rd_data always shows the head entry. Popping when rd_valid=0 has no effect and no error.
- Push while full with no pop: drop the byte, pulse overflow, FIFO contents unchanged.
- Push and pop in the same cycle when full: both succeed, no overflow, fifo_count stays at FIFO_DEPTH.
- Push and pop in the same cycle with 0<count<FIFO_DEPTH: count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is held in a separate counter.
- frame_err and overflow can never both assert in the same cycle.
- Reset mid-frame aborts the frame: no partial byte is pushed and no error pulses are generated.

Test Plan:
1. Defaults; send 0xA5 8N1 at 108 clk/bit -> rd_valid=1 within BIT_PERIOD+3 cycles of stop-bit mid-point; rd_data=0xA5; fifo_count=1; frame_err and overflow never asserted.
2. Drive rx_pin low for 20 cycles, then high -> no push, back in IDLE by cycle ~57. Separately, a 1-cycle low pulse mid-bit inside a 0xFF frame -> received byte is 0xFF (majority vote).
3. Send 0x3C with stop bit=0, holding the line low for 2 bit times, then high, then 0x55 -> exactly one frame_err pulse; 0x3C not stored; 0x55 received with fifo_count=1.
4. Send 17 bytes 0x00..0x10 with rd_en=0 (DEPTH 16) -> fifo_count=16, one overflow pulse on byte 0x10; 16 pops return 0x00..0x0F, then rd_valid=0.
5. With the FIFO full, assert rd_en in the exact cycle of a push (0x77) -> no overflow, count stays 16, and 0x77 is the last byte popped.
6. Assert reset mid-DATA with rx_pin held low, release it, keep the line low for 3 bit times, then send 0x81 -> no byte from the aborted frame or the low period; 0x81 received correctly. Also run DATA_LENGTH=7, STOP_BITS=2 with byte 0x5A -> rd_data=0x5A.
